// File: rtl/parking_pay_gate_ctrl_pkg.sv
// Shared definitions for the parking exit controller: state encoding, bill code width
// and saturating money helpers (operate at 32 bits, callers truncate to their width).
package parking_pkg;

    localparam int BILL_CODE_W = 2;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_BILL = 3'd1;
    localparam logic [2:0] ST_INTAKE    = 3'd2;
    localparam logic [2:0] ST_CHANGE    = 3'd3;
    localparam logic [2:0] ST_STAMP     = 3'd4;
    localparam logic [2:0] ST_GATE      = 3'd5;
    localparam logic [2:0] ST_PASSING   = 3'd6;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] max);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max}) ? max : sum[31:0];
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (b > a) ? 32'd0 : (a - b);
    endfunction

endpackage

// File: rtl/parking_pay_gate_ctrl_cycle_timer.sv
// Up-counter shared by the intake motor and barrier windows: load clears it, done_o is
// high during the limit_i-th enabled cycle after a load.
module cycle_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign done_o = (({1'b0, cnt_q} + (CNT_W+1)'(1)) == {1'b0, limit_i});

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && !done_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/parking_pay_gate_ctrl.sv
// Parking exit controller: fee from hours, timed bill intake, change/refund, ticket stamp
// and a sensor-held exit barrier. Every output is a register that tracks the state entered.
module parking_pay_gate_ctrl
    import parking_pkg::*;
#(
    parameter int HOURS_W    = 2,
    parameter int MONEY_W    = 6,
    parameter int RATE       = 2,
    parameter int BILL_V0    = 1,
    parameter int BILL_V1    = 2,
    parameter int BILL_V2    = 5,
    parameter int BILL_V3    = 10,
    parameter int INTAKE_CYC = 6,
    parameter int GATE_CYC   = 14
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ticket,
    input  logic [HOURS_W-1:0]     hours,
    input  logic                   bill_valid,
    input  logic [BILL_CODE_W-1:0] bill_code,
    input  logic                   cancel,
    input  logic                   sensor,
    output logic                   bill_ack,
    output logic                   motor,
    output logic [MONEY_W-1:0]     balance,
    output logic [MONEY_W-1:0]     change,
    output logic                   change_valid,
    output logic                   stamp,
    output logic                   gate_open
);

    localparam int FEE_W = MONEY_W + HOURS_W;
    localparam int MAX_CYC = (INTAKE_CYC > GATE_CYC) ? INTAKE_CYC : GATE_CYC;
    localparam int TMR_W = $clog2(MAX_CYC + 1);
    localparam logic [MONEY_W-1:0] MONEY_MAX = '1;

    function automatic logic [MONEY_W-1:0] bill_value(input logic [BILL_CODE_W-1:0] code);
        case (code)
            2'd0:    return MONEY_W'(BILL_V0);
            2'd1:    return MONEY_W'(BILL_V1);
            2'd2:    return MONEY_W'(BILL_V2);
            default: return MONEY_W'(BILL_V3);
        endcase
    endfunction

    state_t             state_q, state_d;
    logic [MONEY_W-1:0] balance_q, balance_d;
    logic [MONEY_W-1:0] paid_q, paid_d;
    logic [MONEY_W-1:0] change_q, change_d;
    logic [MONEY_W-1:0] value_q, value_d;
    logic               bill_ack_q, bill_ack_d;
    logic               motor_q, motor_d;
    logic               cv_q, cv_d;
    logic               stamp_q, stamp_d;
    logic               gate_q, gate_d;

    logic [FEE_W-1:0]   fee_full;
    logic [MONEY_W-1:0] fee;
    logic               tmr_load, tmr_en, tmr_done;
    logic [TMR_W-1:0]   tmr_limit;

    assign fee_full = FEE_W'(hours) * FEE_W'(RATE);
    assign fee      = (fee_full > FEE_W'(MONEY_MAX)) ? MONEY_MAX : fee_full[MONEY_W-1:0];

    assign tmr_en    = (state_q == ST_INTAKE) || (state_q == ST_GATE);
    assign tmr_limit = (state_q == ST_GATE) ? TMR_W'(GATE_CYC) : TMR_W'(INTAKE_CYC);

    cycle_timer #(
        .CNT_W (TMR_W)
    ) u_timer (
        .clk     (clk),
        .rst_ni  (reset),
        .load_i  (tmr_load),
        .en_i    (tmr_en),
        .limit_i (tmr_limit),
        .done_o  (tmr_done)
    );

    always_comb begin
        state_d    = state_q;
        balance_d  = balance_q;
        paid_d     = paid_q;
        change_d   = change_q;
        value_d    = value_q;
        bill_ack_d = 1'b0;
        motor_d    = 1'b0;
        cv_d       = 1'b0;
        stamp_d    = 1'b0;
        gate_d     = 1'b0;
        tmr_load   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ticket) begin
                    balance_d = fee;
                    paid_d    = '0;
                    if (fee == '0) begin
                        state_d = ST_STAMP;
                        stamp_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT_BILL;
                    end
                end
            end
            ST_WAIT_BILL: begin
                // Cancel wins over a bill presented in the same cycle.
                if (cancel) begin
                    state_d = ST_IDLE;
                    if (paid_q != '0) begin
                        change_d = paid_q;
                        cv_d     = 1'b1;
                    end
                end else if (bill_valid) begin
                    bill_ack_d = 1'b1;
                    value_d    = bill_value(bill_code);
                    motor_d    = 1'b1;
                    tmr_load   = 1'b1;
                    state_d    = ST_INTAKE;
                end
            end
            ST_INTAKE: begin
                if (tmr_done) begin
                    paid_d = MONEY_W'(sat_add(32'(paid_q), 32'(value_q), 32'(MONEY_MAX)));
                    if (value_q >= balance_q) begin
                        change_d  = MONEY_W'(sat_sub(32'(value_q), 32'(balance_q)));
                        balance_d = '0;
                        cv_d      = 1'b1;
                        state_d   = ST_CHANGE;
                    end else begin
                        balance_d = MONEY_W'(sat_sub(32'(balance_q), 32'(value_q)));
                        state_d   = ST_WAIT_BILL;
                    end
                end else begin
                    motor_d = 1'b1;
                end
            end
            ST_CHANGE: begin
                stamp_d = 1'b1;
                state_d = ST_STAMP;
            end
            ST_STAMP: begin
                gate_d   = 1'b1;
                tmr_load = 1'b1;
                state_d  = ST_GATE;
            end
            ST_GATE: begin
                if (sensor) begin
                    gate_d  = 1'b1;
                    state_d = ST_PASSING;
                end else if (tmr_done) begin
                    state_d = ST_IDLE;
                end else begin
                    gate_d = 1'b1;
                end
            end
            ST_PASSING: begin
                if (sensor) begin
                    gate_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            balance_q  <= '0;
            paid_q     <= '0;
            change_q   <= '0;
            value_q    <= '0;
            bill_ack_q <= 1'b0;
            motor_q    <= 1'b0;
            cv_q       <= 1'b0;
            stamp_q    <= 1'b0;
            gate_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            balance_q  <= balance_d;
            paid_q     <= paid_d;
            change_q   <= change_d;
            value_q    <= value_d;
            bill_ack_q <= bill_ack_d;
            motor_q    <= motor_d;
            cv_q       <= cv_d;
            stamp_q    <= stamp_d;
            gate_q     <= gate_d;
        end
    end

    assign bill_ack     = bill_ack_q;
    assign motor        = motor_q;
    assign balance      = balance_q;
    assign change       = change_q;
    assign change_valid = cv_q;
    assign stamp        = stamp_q;
    assign gate_open    = gate_q;

endmodule

// File: tb/tb_parking_pay_gate_ctrl.sv
// Directed bench for parking_pay_gate_ctrl: a table of payment transactions plus
// hand-written sequences for intake cancel, barrier timeout/hold and reset mid-intake.
module tb_parking_pay_gate_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ticket = 1'b0;
    logic [1:0] hours = 2'd0;
    logic       bill_valid = 1'b0;
    logic [1:0] bill_code = 2'd0;
    logic       cancel = 1'b0;
    logic       sensor = 1'b0;
    logic       bill_ack, motor, change_valid, stamp, gate_open;
    logic [5:0] balance, change;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    parking_pay_gate_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .ticket       (ticket),
        .hours        (hours),
        .bill_valid   (bill_valid),
        .bill_code    (bill_code),
        .cancel       (cancel),
        .sensor       (sensor),
        .bill_ack     (bill_ack),
        .motor        (motor),
        .balance      (balance),
        .change       (change),
        .change_valid (change_valid),
        .stamp        (stamp),
        .gate_open    (gate_open)
    );

    typedef struct {
        logic [1:0]      hours;
        int              nbills;
        logic [2:0][1:0] codes;
        logic            do_cancel;
        int              fee;
        int              bal0;
        int              bal1;
        int              bal2;
        int              chg;
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mk(input logic [1:0] h, input int nb, input logic [1:0] c0,
                                input logic [1:0] c1, input logic [1:0] c2, input logic cn,
                                input int fee, input int b0, input int b1, input int b2,
                                input int chg);
        vec_t v;
        v.hours = h; v.nbills = nb; v.codes = {c2, c1, c0}; v.do_cancel = cn;
        v.fee = fee; v.bal0 = b0; v.bal1 = b1; v.bal2 = b2; v.chg = chg;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic count_motor(output int mcnt, output int cvcnt);
        int guard;
        mcnt = 0; cvcnt = 0; guard = 0;
        while (motor && guard < 50) begin
            mcnt++;
            cvcnt += int'(change_valid);
            tick();
            guard++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int mcnt, cvcnt, cnt, exp_bal;
        ticket = 1'b1; hours = v.hours;
        tick();
        ticket = 1'b0;
        chk("fee_loaded", int'(balance), v.fee);
        if (v.fee == 0) begin
            chk("stamp_no_fee", int'(stamp), 1);
            chk("no_bill_ack", int'(bill_ack), 0);
        end else begin
            for (int i = 0; i < v.nbills; i++) begin
                bill_valid = 1'b1; bill_code = v.codes[i];
                tick();
                bill_valid = 1'b0;
                chk("bill_ack", int'(bill_ack), 1);
                count_motor(mcnt, cvcnt);
                chk("motor_cycles", mcnt, 6);
                exp_bal = (i == 0) ? v.bal0 : (i == 1) ? v.bal1 : v.bal2;
                chk("balance", int'(balance), exp_bal);
            end
            if (v.do_cancel) begin
                cancel = 1'b1;
                tick();
                cancel = 1'b0;
                chk("refund_valid", int'(change_valid), 1);
                chk("refund_amount", int'(change), v.chg);
                cnt = 0;
                repeat (20) begin
                    tick();
                    cnt += int'(stamp) + int'(gate_open);
                end
                chk("cancel_no_stamp_gate", cnt, 0);
                return;
            end
            chk("change_valid", int'(change_valid), 1);
            chk("change_amount", int'(change), v.chg);
            tick();
            chk("stamp", int'(stamp), 1);
            chk("change_pulse_1cyc", int'(change_valid), 0);
        end
        tick();
        chk("gate_open", int'(gate_open), 1);
        chk("stamp_once", int'(stamp), 0);
        sensor = 1'b1;
        repeat (3) tick();
        chk("gate_held_sensor", int'(gate_open), 1);
        sensor = 1'b0;
        tick();
        chk("gate_closed", int'(gate_open), 0);
        tick();
    endtask

    initial begin
        int mcnt, cvcnt, cnt, guard;

        vecs[0] = mk(2'd2, 1, 2'd3, 2'd0, 2'd0, 1'b0, 4, 0, 0, 0, 6);
        vecs[1] = mk(2'd3, 3, 2'd1, 2'd1, 2'd1, 1'b0, 6, 4, 2, 0, 0);
        vecs[2] = mk(2'd0, 0, 2'd0, 2'd0, 2'd0, 1'b0, 0, 0, 0, 0, 0);
        vecs[3] = mk(2'd3, 1, 2'd2, 2'd0, 2'd0, 1'b1, 6, 1, 0, 0, 5);
        vecs[4] = mk(2'd1, 2, 2'd0, 2'd2, 2'd0, 1'b0, 2, 1, 0, 0, 4);
        vecs[5] = mk(2'd3, 3, 2'd0, 2'd0, 2'd3, 1'b0, 6, 5, 4, 0, 6);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_motor", int'(motor), 0);
        chk("rst_gate", int'(gate_open), 0);
        chk("rst_balance", int'(balance), 0);
        chk("rst_outputs", int'(bill_ack) + int'(change_valid) + int'(stamp) + int'(change), 0);
        reset = 1'b1;
        tick();

        for (int k = 0; k < 6; k++) begin
            run_vec(vecs[k]);
        end

        // Cancel held through intake is ignored until WAIT_BILL, then refunds.
        ticket = 1'b1; hours = 2'd3;
        tick();
        ticket = 1'b0;
        bill_valid = 1'b1; bill_code = 2'd1;
        tick();
        bill_valid = 1'b0; cancel = 1'b1;
        count_motor(mcnt, cvcnt);
        chk("cancel_intake_motor", mcnt, 6);
        chk("cancel_intake_no_cv", cvcnt, 0);
        chk("cancel_intake_balance", int'(balance), 4);
        tick();
        cancel = 1'b0;
        chk("cancel_refund_valid", int'(change_valid), 1);
        chk("cancel_refund_amount", int'(change), 2);
        cnt = 0;
        repeat (20) begin
            tick();
            cnt += int'(stamp) + int'(gate_open);
        end
        chk("cancel_refund_no_gate", cnt, 0);

        // Barrier timeout with no vehicle.
        ticket = 1'b1; hours = 2'd0;
        tick();
        ticket = 1'b0;
        chk("timeout_stamp", int'(stamp), 1);
        tick();
        cnt = 0; guard = 0;
        while (gate_open && guard < 100) begin
            cnt++;
            tick();
            guard++;
        end
        chk("gate_timeout_cycles", cnt, 14);

        // Vehicle held under the barrier longer than the timeout window.
        ticket = 1'b1;
        tick();
        ticket = 1'b0;
        tick();
        sensor = 1'b1;
        cnt = 0;
        repeat (20) begin
            tick();
            cnt += int'(gate_open);
        end
        chk("gate_held_20", cnt, 20);
        sensor = 1'b0;
        tick();
        chk("gate_release", int'(gate_open), 0);
        tick();

        // Asynchronous reset in the middle of an intake.
        ticket = 1'b1; hours = 2'd2;
        tick();
        ticket = 1'b0;
        bill_valid = 1'b1; bill_code = 2'd3;
        tick();
        bill_valid = 1'b0;
        tick();
        chk("pre_reset_motor", int'(motor), 1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_motor", int'(motor), 0);
        chk("async_rst_balance", int'(balance), 0);
        chk("async_rst_gate", int'(gate_open), 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();
        chk("post_reset_idle_motor", int'(motor), 0);
        chk("post_reset_idle_balance", int'(balance), 0);

        run_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
